regfile_hilo: RTL and testbench

//   Architectural state sink for the writeback end of the pipeline. Holds the 32 MIPS GPRs and the HI/LO pair.

---
 rtl/regfile_hilo_if.sv | 39 +++
 rtl/regfile_hilo.sv | 57 +++++
 tb/tb_regfile_hilo.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_hilo_if.sv
// regfile_hilo_if: writeback/read bundle between the pipeline and the register file
//   wb_write_enable/addr/data            GPR commit from WB
//   wb_write_hilo_enable/hi_data/lo_data HI/LO commit from WB
//   read1_*/read2_*                      GPR read ports for ID/EX
//   hi_data/lo_data                      current HI/LO
//   master: pipeline side, slave: register file side
interface regfile_hilo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  wb_write_enable;
    logic [ADDR_WIDTH-1:0] wb_write_addr;
    logic [DATA_WIDTH-1:0] wb_write_data;
    logic                  wb_write_hilo_enable;
    logic [DATA_WIDTH-1:0] wb_write_hi_data;
    logic [DATA_WIDTH-1:0] wb_write_lo_data;
    logic                  read1_enable;
    logic [ADDR_WIDTH-1:0] read1_addr;
    logic [DATA_WIDTH-1:0] read1_data;
    logic                  read2_enable;
    logic [ADDR_WIDTH-1:0] read2_addr;
    logic [DATA_WIDTH-1:0] read2_data;
    logic [DATA_WIDTH-1:0] hi_data;
    logic [DATA_WIDTH-1:0] lo_data;

    modport master (
        output wb_write_enable, wb_write_addr, wb_write_data,
        output wb_write_hilo_enable, wb_write_hi_data, wb_write_lo_data,
        output read1_enable, read1_addr, read2_enable, read2_addr,
        input  read1_data, read2_data, hi_data, lo_data
    );

    modport slave (
        input  wb_write_enable, wb_write_addr, wb_write_data,
        input  wb_write_hilo_enable, wb_write_hi_data, wb_write_lo_data,
        input  read1_enable, read1_addr, read2_enable, read2_addr,
        output read1_data, read2_data, hi_data, lo_data
    );
endinterface

// File: rtl/regfile_hilo.sv
// regfile_hilo: 32-entry MIPS GPR file plus HI/LO, written at WB, read combinationally by ID/EX
//   clock  rising-edge pipeline clock
//   reset  asynchronous active-low; clears all state and forces every output to 0
//   bus    regfile_hilo_if.slave: WB write bundles, two GPR read ports, HI/LO outputs
// Build option: define REGFILE_BYPASS_EN to forward same-cycle WB writes to the read ports and HI/LO.
// NUM_REGS must equal 2**ADDR_WIDTH.
module regfile_hilo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input logic           clock,
    input logic           reset,
    regfile_hilo_if.slave bus
);
    logic [DATA_WIDTH-1:0] gpr [NUM_REGS];
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  hit1;
    logic                  hit2;
    logic                  hit_hilo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
            hi <= '0;
            lo <= '0;
        end else begin
            if (bus.wb_write_enable && bus.wb_write_addr != '0) gpr[bus.wb_write_addr] <= bus.wb_write_data;
            if (bus.wb_write_hilo_enable) begin
                hi <= bus.wb_write_hi_data;
                lo <= bus.wb_write_lo_data;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Address 0 is excluded below by the read mux, so the hit only needs the address match.
    assign hit1     = bus.wb_write_enable && bus.read1_addr == bus.wb_write_addr;
    assign hit2     = bus.wb_write_enable && bus.read2_addr == bus.wb_write_addr;
    assign hit_hilo = bus.wb_write_hilo_enable;
`else
    assign hit1     = 1'b0;
    assign hit2     = 1'b0;
    assign hit_hilo = 1'b0;
`endif

    // Outputs are gated by reset so forwarded write data cannot leak out while reset is held.
    always_comb begin
        bus.read1_data = (!reset || !bus.read1_enable || bus.read1_addr == '0) ? '0 :
                         hit1 ? bus.wb_write_data : gpr[bus.read1_addr];
        bus.read2_data = (!reset || !bus.read2_enable || bus.read2_addr == '0) ? '0 :
                         hit2 ? bus.wb_write_data : gpr[bus.read2_addr];
        bus.hi_data    = !reset ? '0 : hit_hilo ? bus.wb_write_hi_data : hi;
        bus.lo_data    = !reset ? '0 : hit_hilo ? bus.wb_write_lo_data : lo;
    end
endmodule

// File: tb/tb_regfile_hilo.sv
// tb_regfile_hilo: directed self-checking bench for regfile_hilo
module tb_regfile_hilo;
    logic clock;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] exp_v;

    regfile_hilo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    regfile_hilo #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_write_enable = we;
        bus.wb_write_addr   = a;
        bus.wb_write_data   = d;
    endtask

    task automatic set_hilo(input logic we, input logic [31:0] h, input logic [31:0] l);
        bus.wb_write_hilo_enable = we;
        bus.wb_write_hi_data     = h;
        bus.wb_write_lo_data     = l;
    endtask

    task automatic set_rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        bus.read1_enable = e1;
        bus.read1_addr   = a1;
        bus.read2_enable = e2;
        bus.read2_addr   = a2;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0);
        set_hilo(1'b0, 32'h0, 32'h0);
        set_rd(1'b1, 5'd5, 1'b1, 5'd31);
        #3;
        chk("reset_rd1", bus.read1_data, 32'h0);
        chk("reset_rd2", bus.read2_data, 32'h0);
        chk("reset_hi", bus.hi_data, 32'h0);
        chk("reset_lo", bus.lo_data, 32'h0);
        #9 reset = 1'b1;

        // Test 1: write, then asynchronous reset mid-cycle
        set_wr(1'b1, 5'd5, 32'hDEADBEEF);
        set_hilo(1'b1, 32'h1, 32'h2);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_hilo(1'b0, 32'h0, 32'h0);
        #1;
        chk("t1_rd5", bus.read1_data, 32'hDEADBEEF);
        chk("t1_hi", bus.hi_data, 32'h1);
        chk("t1_lo", bus.lo_data, 32'h2);
        reset = 1'b0;
        #1;
        chk("t1_rst_rd5", bus.read1_data, 32'h0);
        chk("t1_rst_hi", bus.hi_data, 32'h0);
        chk("t1_rst_lo", bus.lo_data, 32'h0);
        set_wr(1'b1, 5'd6, 32'h66666666);
        set_hilo(1'b1, 32'h77, 32'h88);
        set_rd(1'b1, 5'd6, 1'b1, 5'd5);
        #1;
        chk("t1_rst_fwd6", bus.read1_data, 32'h0);
        chk("t1_rst_fwdhi", bus.hi_data, 32'h0);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_hilo(1'b0, 32'h0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("t1_lost6", bus.read1_data, 32'h0);
        chk("t1_cleared5", bus.read2_data, 32'h0);
        chk("t1_lost_hi", bus.hi_data, 32'h0);
        chk("t1_lost_lo", bus.lo_data, 32'h0);
        step();

        // Test 2: $0 is hardwired
        set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        chk("t2_fwd_rd1", bus.read1_data, 32'h0);
        chk("t2_fwd_rd2", bus.read2_data, 32'h0);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("t2_rd1", bus.read1_data, 32'h0);
        chk("t2_rd2", bus.read2_data, 32'h0);
        step();
        chk("t2_rd1_later", bus.read1_data, 32'h0);
        chk("t2_rd2_later", bus.read2_data, 32'h0);

        // Test 3: same-edge write and read of gpr[7]
        set_wr(1'b1, 5'd7, 32'h12345678);
        set_rd(1'b1, 5'd7, 1'b0, 5'd7);
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'h12345678;
`else
        exp_v = 32'h0;
`endif
        #1;
        chk("t3_same_cycle", bus.read1_data, exp_v);
        chk("t3_rd2_disabled", bus.read2_data, 32'h0);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("t3_next_cycle", bus.read1_data, 32'h12345678);

        // Test 4: read enables gate the ports independently
        set_wr(1'b1, 5'd3, 32'hA5A5A5A5);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(1'b0, 5'd3, 1'b1, 5'd3);
        #1;
        chk("t4_rd1_off", bus.read1_data, 32'h0);
        chk("t4_rd2_on", bus.read2_data, 32'hA5A5A5A5);

        // Test 5: GPR and HI/LO written on the same edge
        set_wr(1'b1, 5'd9, 32'h11);
        set_hilo(1'b1, 32'hAAAA0000, 32'h0000BBBB);
        set_rd(1'b1, 5'd9, 1'b1, 5'd7);
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'hAAAA0000;
`else
        exp_v = 32'h0;
`endif
        #1;
        chk("t5_hi_same_cycle", bus.hi_data, exp_v);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_hilo(1'b0, 32'h0, 32'h0);
        #1;
        chk("t5_rd9", bus.read1_data, 32'h11);
        chk("t5_rd7", bus.read2_data, 32'h12345678);
        chk("t5_hi", bus.hi_data, 32'hAAAA0000);
        chk("t5_lo", bus.lo_data, 32'h0000BBBB);
        set_hilo(1'b0, 32'h5, 32'h6);
        #1;
        chk("t5_hi_held", bus.hi_data, 32'hAAAA0000);
        chk("t5_lo_held", bus.lo_data, 32'h0000BBBB);

        // Test 6: write every GPR with its index and sweep both ports
        for (int i = 1; i < 32; i++) begin
            set_wr(1'b1, 5'(i), 32'(i));
            step();
        end
        set_wr(1'b0, 5'd0, 32'h0);
        for (int a = 0; a < 32; a++) begin
            set_rd(1'b1, 5'(a), 1'b1, 5'(31 - a));
            #1;
            chk($sformatf("t6_rd1_%0d", a), bus.read1_data, 32'(a));
            chk($sformatf("t6_rd2_%0d", 31 - a), bus.read2_data, 32'(31 - a));
        end
        set_rd(1'b1, 5'd17, 1'b1, 5'd17);
        #1;
        chk("t6_same_addr", bus.read1_data, bus.read2_data === 32'd17 ? 32'd17 : 32'hFFFFFFFF);
        chk("t6_hi_untouched", bus.hi_data, 32'hAAAA0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
